// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, header field placement and the
// transmitter FSM state type, plus a helper that packs a header flit.
`ifndef DATA_WIDTH
`include "globe_def.sv"
`endif

package noc_pkg;

   localparam int unsigned FLIT_W    = `DATA_WIDTH;
   localparam int unsigned COORD_W   = 7;
   localparam int unsigned DST_X_LSB = 0;
   localparam int unsigned DST_Y_LSB = 7;
   localparam int unsigned SRC_X_LSB = 14;
   localparam int unsigned SRC_Y_LSB = 21;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } ni_tx_state_e;

   // Header flit: destination in the low bits, source above it, rest zero.
   function automatic logic [FLIT_W-1:0] make_header(
      input logic [COORD_W-1:0] dst_x,
      input logic [COORD_W-1:0] dst_y,
      input logic [COORD_W-1:0] src_x,
      input logic [COORD_W-1:0] src_y
   );
      logic [FLIT_W-1:0] h;
      h = '0;
      h[DST_X_LSB +: COORD_W] = dst_x;
      h[DST_Y_LSB +: COORD_W] = dst_y;
      h[SRC_X_LSB +: COORD_W] = src_x;
      h[SRC_Y_LSB +: COORD_W] = src_y;
      return h;
   endfunction

endpackage

// File: rtl/globe_def.sv
// Global project definitions shared by every tile.
//   DATA_WIDTH : flit width in bits; must be at least 28 to hold a header.
`ifndef GLOBE_DEF_SV
`define GLOBE_DEF_SV
`define DATA_WIDTH 32
`endif

// File: rtl/ni_out_reg.sv
// Single-entry valid/ready output register feeding the router injection port.
//   clk, reset           : clock, async active-high reset
//   load, load_data/last : write a new flit (only asserted while free)
//   tx_ready             : downstream accepts the current flit
//   tx_data/valid/last   : registered flit toward the router
//   free                 : register empty or unloading this cycle
module ni_out_reg
   import noc_pkg::*;
#(
   parameter int unsigned W = FLIT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         load_last,
   input  logic         tx_ready,
   output logic [W-1:0] tx_data,
   output logic         tx_valid,
   output logic         tx_last,
   output logic         free
);

   assign free = !tx_valid || tx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data  <= '0;
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
      end else if (load) begin
         tx_data  <= load_data;
         tx_valid <= 1'b1;
         tx_last  <= load_last;
      end else if (free) begin
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
      end
   end

endmodule

// File: rtl/ni_packet_tx.sv
// Network-interface transmitter: turns IP packet requests into a header
// flit followed by req_len payload flits on the router injection port.
//   req_*  : packet request (destination, payload length) from the IP
//   pl_*   : payload flit stream from the IP
//   tx_*   : flit stream to the router, tx_last marks the final flit
//   busy   : packet in progress or flit pending
//   pkt_cnt: completed packets (last-flit transfers), wrapping
module ni_packet_tx
   import noc_pkg::*;
#(
   parameter int unsigned X_CUR = 2,
   parameter int unsigned Y_CUR = 2,
   parameter int unsigned LEN_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [6:0]         req_dst_x,
   input  logic [6:0]         req_dst_y,
   input  logic [LEN_W-1:0]   req_len,
   input  logic [FLIT_W-1:0]  pl_data,
   input  logic               pl_valid,
   output logic               pl_ready,
   output logic [FLIT_W-1:0]  tx_data,
   output logic               tx_valid,
   output logic               tx_last,
   input  logic               tx_ready,
   output logic               busy,
   output logic [15:0]        pkt_cnt
);

   ni_tx_state_e      state, state_nxt;
   logic [LEN_W-1:0]  remaining;
   logic              free, load, load_last, req_fire, pl_fire;
   logic [FLIT_W-1:0] load_data;

   ni_out_reg #(.W(FLIT_W)) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_last   (tx_last),
      .free      (free)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         remaining <= '0;
      end else begin
         state <= state_nxt;
         if (req_fire)
            remaining <= req_len;
         else if (pl_fire)
            remaining <= remaining - LEN_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      pl_ready  = 1'b0;
      load_data = pl_data;
      load_last = 1'b0;
      // Ready is masked during reset so every output reads 0 while it is held.
      unique case (state)
         ST_IDLE: begin
            req_ready = free && !reset;
            load_data = make_header(req_dst_x, req_dst_y,
                                    COORD_W'(X_CUR), COORD_W'(Y_CUR));
            load_last = (req_len == '0);
            if (req_valid && req_ready && (req_len != '0))
               state_nxt = ST_BODY;
         end
         ST_BODY: begin
            pl_ready  = free && !reset;
            load_last = (remaining == LEN_W'(1));
            if (pl_valid && pl_ready && (remaining == LEN_W'(1)))
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign req_fire = req_valid && req_ready;
   assign pl_fire  = pl_valid && pl_ready;
   assign load     = req_fire || pl_fire;
   assign busy     = (state == ST_BODY) || tx_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pkt_cnt <= '0;
      else if (tx_valid && tx_ready && tx_last)
         pkt_cnt <= pkt_cnt + 16'd1;
   end

endmodule

// File: tb/tb_ni_packet_tx.sv
// Directed bench for ni_packet_tx (X_CUR=Y_CUR=2, LEN_W=8).
module tb_ni_packet_tx;
   import noc_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid, req_ready;
   logic [6:0]        req_dst_x, req_dst_y;
   logic [7:0]        req_len;
   logic [FLIT_W-1:0] pl_data;
   logic              pl_valid, pl_ready;
   logic [FLIT_W-1:0] tx_data;
   logic              tx_valid, tx_last, tx_ready, busy;
   logic [15:0]       pkt_cnt;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   ni_packet_tx #(.X_CUR(2), .Y_CUR(2), .LEN_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_dst_x (req_dst_x),
      .req_dst_y (req_dst_y),
      .req_len   (req_len),
      .pl_data   (pl_data),
      .pl_valid  (pl_valid),
      .pl_ready  (pl_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_last   (tx_last),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .pkt_cnt   (pkt_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flit(input string tag, input logic [31:0] d, input logic l);
      chk({tag, ".valid"}, 64'(tx_valid), 64'd1);
      chk({tag, ".data"}, 64'(tx_data), 64'(d));
      chk({tag, ".last"}, 64'(tx_last), 64'(l));
   endtask

   task automatic request(input logic [6:0] dx, input logic [6:0] dy, input logic [7:0] len);
      req_valid = 1'b1;
      req_dst_x = dx;
      req_dst_y = dy;
      req_len   = len;
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_dst_x = '0; req_dst_y = '0; req_len = '0;
      pl_data = '0; pl_valid = 1'b0; tx_ready = 1'b1;

      // Reset state
      #3;
      chk("rst.tx_valid", 64'(tx_valid), 64'd0);
      chk("rst.tx_data", 64'(tx_data), 64'd0);
      chk("rst.tx_last", 64'(tx_last), 64'd0);
      chk("rst.pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.pl_ready", 64'(pl_ready), 64'd0);
      chk("rst.req_ready", 64'(req_ready), 64'd0);
      @(negedge clk); reset = 1'b0; #1;
      chk("rst.req_ready_after", 64'(req_ready), 64'd1);

      // Basic packet: dst (1,3), len 2 -> header 1|3<<7|2<<14|2<<21 = 0x408181
      request(7'd1, 7'd3, 8'd2);
      pl_valid = 1'b1; pl_data = 32'hA5;
      #1 chk("basic.pl_ready_idle", 64'(pl_ready), 64'd0);
      tick(); chk_flit("basic.hdr", 32'h0040_8181, 1'b0);
      req_valid = 1'b0;
      tick(); chk_flit("basic.p0", 32'hA5, 1'b0);
      pl_data = 32'h5A;
      tick(); chk_flit("basic.p1", 32'h5A, 1'b1);
      pl_valid = 1'b0;
      tick();
      chk("basic.valid_drop", 64'(tx_valid), 64'd0);
      chk("basic.pkt_cnt", 64'(pkt_cnt), 64'd1);
      chk("basic.req_ready", 64'(req_ready), 64'd1);
      chk("basic.busy", 64'(busy), 64'd0);

      // Zero-length packets back to back
      request(7'd0, 7'd0, 8'd0);
      tick(); chk_flit("zero.hdr0", 32'h0040_8000, 1'b1);
      chk("zero.req_ready", 64'(req_ready), 64'd1);
      chk("zero.pl_ready", 64'(pl_ready), 64'd0);
      request(7'd1, 7'd1, 8'd0);
      tick(); chk_flit("zero.hdr1", 32'h0040_8081, 1'b1);
      chk("zero.pkt_cnt_mid", 64'(pkt_cnt), 64'd2);
      req_valid = 1'b0;
      tick();
      chk("zero.valid_drop", 64'(tx_valid), 64'd0);
      chk("zero.pkt_cnt", 64'(pkt_cnt), 64'd3);

      // Backpressure on payload 2 of a len=4 packet, dst (2,1) -> 0x408082
      request(7'd2, 7'd1, 8'd4);
      tick(); chk_flit("bp.hdr", 32'h0040_8082, 1'b0);
      req_valid = 1'b0; pl_valid = 1'b1; pl_data = 32'h11;
      tick(); chk_flit("bp.p0", 32'h11, 1'b0);
      pl_data = 32'h22;
      tick(); chk_flit("bp.p1", 32'h22, 1'b0);
      pl_data = 32'h33; tx_ready = 1'b0;
      #1 chk("bp.pl_ready_comb", 64'(pl_ready), 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_flit("bp.hold", 32'h22, 1'b0);
         chk("bp.pl_ready", 64'(pl_ready), 64'd0);
         chk("bp.req_ready", 64'(req_ready), 64'd0);
      end
      tx_ready = 1'b1;
      #1 chk("bp.pl_ready_release", 64'(pl_ready), 64'd1);
      tick(); chk_flit("bp.p2", 32'h33, 1'b0);
      pl_data = 32'h44;
      tick(); chk_flit("bp.p3", 32'h44, 1'b1);
      pl_valid = 1'b0;
      tick();
      chk("bp.valid_drop", 64'(tx_valid), 64'd0);
      chk("bp.pkt_cnt", 64'(pkt_cnt), 64'd4);

      // IP bubble in a len=3 packet, dst (3,3) -> 0x408183
      request(7'd3, 7'd3, 8'd3);
      tick(); chk_flit("bub.hdr", 32'h0040_8183, 1'b0);
      req_valid = 1'b0; pl_valid = 1'b1; pl_data = 32'h01;
      tick(); chk_flit("bub.p0", 32'h01, 1'b0);
      pl_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bub.tx_valid", 64'(tx_valid), 64'd0);
         chk("bub.busy", 64'(busy), 64'd1);
         chk("bub.req_ready", 64'(req_ready), 64'd0);
      end
      pl_valid = 1'b1; pl_data = 32'h02;
      tick(); chk_flit("bub.p1", 32'h02, 1'b0);
      pl_data = 32'h03;
      tick(); chk_flit("bub.p2", 32'h03, 1'b1);
      pl_valid = 1'b0;
      tick();
      chk("bub.pkt_cnt", 64'(pkt_cnt), 64'd5);
      chk("bub.busy_end", 64'(busy), 64'd0);

      // Reset after header + 1 payload of len=5, dst (0,1) -> 0x408080
      request(7'd0, 7'd1, 8'd5);
      tick(); chk_flit("rmid.hdr", 32'h0040_8080, 1'b0);
      req_valid = 1'b0; pl_valid = 1'b1; pl_data = 32'hAA;
      tick(); chk_flit("rmid.p0", 32'hAA, 1'b0);
      pl_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rmid.tx_valid", 64'(tx_valid), 64'd0);
      chk("rmid.tx_data", 64'(tx_data), 64'd0);
      chk("rmid.pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("rmid.busy", 64'(busy), 64'd0);
      @(negedge clk); reset = 1'b0;
      #1 chk("rmid.req_ready", 64'(req_ready), 64'd1);
      // New len=1 packet, dst (1,0) -> 0x408001
      request(7'd1, 7'd0, 8'd1);
      tick(); chk_flit("rmid.new_hdr", 32'h0040_8001, 1'b0);
      req_valid = 1'b0; pl_valid = 1'b1; pl_data = 32'hBEEF;
      tick(); chk_flit("rmid.new_p0", 32'hBEEF, 1'b1);
      pl_valid = 1'b0;
      tick();
      chk("rmid.pkt_cnt_new", 64'(pkt_cnt), 64'd1);

      // Counter wrap: 65537 more zero-length packets, 1 + 65537 wraps to 2
      request(7'd0, 7'd0, 8'd0);
      repeat (65537) tick();
      req_valid = 1'b0;
      tick();
      chk("wrap.pkt_cnt", 64'(pkt_cnt), 64'd2);
      chk("wrap.tx_valid", 64'(tx_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
